// File: rtl/game_sequencer.sv
// game_sequencer: per-frame scheduler for the layer offsets of the VGA
// compositing datapath. Sequence is COUNTDOWN -> LOGO_SCROLL -> HEAD_SLIDE ->
// RUN. All offsets are registered, signed and update once per frame, on the
// clock after frame_tick. Lane selection in RUN follows debounced buttons
// and takes effect immediately.
//
// Ports:
//   CLK100MHZ     in   system clock
//   CPU_RESETN    in   asynchronous active-low reset
//   VGA_VS        in   vsync, asynchronous; synchronised here, never a clock
//   BTNL / BTNR   in   raw lane buttons (left: lane+1, right: lane-1)
//   restart       in   one-cycle pulse, returns the sequence to COUNTDOWN
//   frame_tick    out  one-cycle pulse per vsync rising edge
//   state         out  0 COUNTDOWN, 1 LOGO_SCROLL, 2 HEAD_SLIDE, 3 RUN
//   logo_hoffset  out  logo layer hoffset
//   head_hoffset  out  head layer hoffset (lane * LANE_OFFSET)
//   head_voffset  out  head layer voffset (slide-in)
//   coin_hoffset  out  coin layer hoffset
//   coin_voffset  out  coin layer voffset
//   coin_valid    out  coin layer enabled (RUN only)
module game_sequencer #(
  parameter int DATA_W           = 12,
  parameter int COUNTDOWN_FRAMES = 50,
  parameter int LOGO_STEP        = 30,
  parameter int LOGO_END         = -600,
  parameter int HEAD_START       = -170,
  parameter int HEAD_STEP        = 17,
  parameter int LANE_OFFSET      = 100,
  parameter int COIN_STEPS       = 60,
  parameter int DEBOUNCE_CYCLES  = 1000000
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  input  logic                     VGA_VS,
  input  logic                     BTNL,
  input  logic                     BTNR,
  input  logic                     restart,
  output logic                     frame_tick,
  output logic [1:0]               state,
  output logic signed [DATA_W-1:0] logo_hoffset,
  output logic signed [DATA_W-1:0] head_hoffset,
  output logic signed [DATA_W-1:0] head_voffset,
  output logic signed [DATA_W-1:0] coin_hoffset,
  output logic signed [DATA_W-1:0] coin_voffset,
  output logic                     coin_valid
);

  localparam int CD_W = $clog2(COUNTDOWN_FRAMES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic signed [DATA_W-1:0] LOGO_END_S   = DATA_W'(LOGO_END);
  localparam logic signed [DATA_W-1:0] HEAD_START_S = DATA_W'(HEAD_START);
  localparam logic signed [DATA_W-1:0] COIN_H0      = DATA_W'(-200);
  localparam logic signed [DATA_W-1:0] COIN_V0      = DATA_W'(-40);

  typedef enum logic [1:0] {
    S_COUNTDOWN = 2'd0,
    S_LOGO      = 2'd1,
    S_HEAD      = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  // Logo scroll step, clamped at LOGO_END; one extra bit so the
  // subtraction itself can never wrap before the clamp.
  function automatic logic signed [DATA_W-1:0] sat_logo(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] t;
    t = {x[DATA_W-1], x} - (DATA_W+1)'(LOGO_STEP);
    if (t < (DATA_W+1)'(LOGO_END)) return LOGO_END_S;
    return t[DATA_W-1:0];
  endfunction

  // Head slide step, clamped at 0.
  function automatic logic signed [DATA_W-1:0] sat_head(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] t;
    t = {x[DATA_W-1], x} + (DATA_W+1)'(HEAD_STEP);
    if (t > 0) return '0;
    return t[DATA_W-1:0];
  endfunction

  // Saturating lane step; simultaneous edges cancel.
  function automatic logic signed [1:0] lane_step(input logic signed [1:0] l, input logic [1:0] rise);
    logic signed [1:0] r;
    r = l;
    if (rise == 2'b01 && l != 2'sd1)  r = l + 2'sd1;
    if (rise == 2'b10 && l != -2'sd1) r = l - 2'sd1;
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] lane_to_offset(input logic signed [1:0] l);
    if (l == 2'sd1)  return DATA_W'(LANE_OFFSET);
    if (l == -2'sd1) return DATA_W'(-LANE_OFFSET);
    return '0;
  endfunction

  // ---- frame tick: 2-flop sync, edge detect, registered pulse ----
  logic vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      vs_meta_q    <= 1'b0;
      vs_sync_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_meta_q    <= VGA_VS;
      vs_sync_q    <= vs_meta_q;
      vs_prev_q    <= vs_sync_q;
      frame_tick_q <= vs_sync_q & ~vs_prev_q;
    end
  end

  // ---- buttons: bit 0 = BTNL, bit 1 = BTNR ----
  logic [1:0]      btn_raw;
  logic [1:0]      btn_meta_q, btn_sync_q, btn_db_q, btn_db_prev_q;
  logic [DB_W-1:0] btn_cnt_q [2];
  logic [1:0]      btn_rise;

  assign btn_raw  = {BTNR, BTNL};
  assign btn_rise = btn_db_q & ~btn_db_prev_q;

  // The counter only runs while the synchronised level differs from the
  // accepted level; any return to the accepted level reloads it.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      btn_meta_q    <= '0;
      btn_sync_q    <= '0;
      btn_db_q      <= '0;
      btn_db_prev_q <= '0;
      for (int b = 0; b < 2; b++) btn_cnt_q[b] <= '0;
    end else begin
      btn_meta_q    <= btn_raw;
      btn_sync_q    <= btn_meta_q;
      btn_db_prev_q <= btn_db_q;
      for (int b = 0; b < 2; b++) begin
        if (btn_sync_q[b] == btn_db_q[b]) begin
          btn_cnt_q[b] <= '0;
        end else if (btn_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_cnt_q[b] <= '0;
          btn_db_q[b]  <= btn_sync_q[b];
        end else begin
          btn_cnt_q[b] <= btn_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // ---- sequencer ----
  state_e                     state_q, state_d;
  logic [CD_W-1:0]            countdown_q, countdown_d;
  logic signed [DATA_W-1:0]   logo_q, logo_d;
  logic signed [DATA_W-1:0]   headv_q, headv_d;
  logic signed [DATA_W-1:0]   headh_q, headh_d;
  logic signed [1:0]          lane_q, lane_d;
  logic [5:0]                 coinloc_q, coinloc_d;
  logic signed [DATA_W-1:0]   coinh_q, coinh_d;
  logic signed [DATA_W-1:0]   coinv_q, coinv_d;
  logic                       coin_valid_q, coin_valid_d;
  logic signed [DATA_W-1:0]   loc_s;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= S_COUNTDOWN;
      countdown_q  <= CD_W'(COUNTDOWN_FRAMES);
      logo_q       <= '0;
      headv_q      <= HEAD_START_S;
      headh_q      <= '0;
      lane_q       <= '0;
      coinloc_q    <= '0;
      coinh_q      <= COIN_H0;
      coinv_q      <= COIN_V0;
      coin_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      countdown_q  <= countdown_d;
      logo_q       <= logo_d;
      headv_q      <= headv_d;
      headh_q      <= headh_d;
      lane_q       <= lane_d;
      coinloc_q    <= coinloc_d;
      coinh_q      <= coinh_d;
      coinv_q      <= coinv_d;
      coin_valid_q <= coin_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    logo_d      = logo_q;
    headv_d     = headv_q;
    lane_d      = lane_q;
    coinloc_d   = coinloc_q;
    coinh_d     = coinh_q;
    coinv_d     = coinv_q;
    loc_s       = '0;

    // restart beats a coincident frame_tick: that tick is dropped.
    if (restart) begin
      state_d     = S_COUNTDOWN;
      countdown_d = CD_W'(COUNTDOWN_FRAMES);
      logo_d      = '0;
      headv_d     = HEAD_START_S;
      lane_d      = '0;
      coinloc_d   = '0;
      coinh_d     = COIN_H0;
      coinv_d     = COIN_V0;
    end else begin
      if (frame_tick_q) begin
        case (state_q)
          S_COUNTDOWN: begin
            if (countdown_q == CD_W'(1)) begin
              countdown_d = '0;
              state_d     = S_LOGO;
            end else begin
              countdown_d = countdown_q - 1'b1;
            end
          end
          S_LOGO: begin
            logo_d = sat_logo(logo_q);
            if (logo_d == LOGO_END_S) state_d = S_HEAD;
          end
          S_HEAD: begin
            headv_d = sat_head(headv_q);
            if (headv_d == '0) state_d = S_RUN;
          end
          default: begin
            coinloc_d = (coinloc_q == 6'(COIN_STEPS - 1)) ? 6'd0 : coinloc_q + 6'd1;
            loc_s     = DATA_W'(coinloc_d);
            coinh_d   = COIN_H0 + loc_s;
            coinv_d   = COIN_V0 - ((loc_s <<< 2) + (loc_s <<< 1));
          end
        endcase
      end
      // Button edges outside RUN are simply dropped.
      if (state_q == S_RUN) lane_d = lane_step(lane_q, btn_rise);
    end

    headh_d      = lane_to_offset(lane_d);
    coin_valid_d = (state_d == S_RUN);
  end

  assign frame_tick   = frame_tick_q;
  assign state        = state_q;
  assign logo_hoffset = logo_q;
  assign head_hoffset = headh_q;
  assign head_voffset = headv_q;
  assign coin_hoffset = coinh_q;
  assign coin_voffset = coinv_q;
  assign coin_valid   = coin_valid_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vs = 1'b0;
  logic               btnl = 1'b0;
  logic               btnr = 1'b0;
  logic               restart = 1'b0;
  logic               frame_tick;
  logic [1:0]         state;
  logic signed [11:0] logo_h, head_h, head_v, coin_h, coin_v;
  logic               coin_valid;

  int errors = 0;
  int checks = 0;

  game_sequencer #(
    .COUNTDOWN_FRAMES(3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .VGA_VS      (vs),
    .BTNL        (btnl),
    .BTNR        (btnr),
    .restart     (restart),
    .frame_tick  (frame_tick),
    .state       (state),
    .logo_hoffset(logo_h),
    .head_hoffset(head_h),
    .head_voffset(head_v),
    .coin_hoffset(coin_h),
    .coin_voffset(coin_v),
    .coin_valid  (coin_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_state"}, state, 0);
    check({p, "_logo"}, logo_h, 0);
    check({p, "_headv"}, head_v, -170);
    check({p, "_headh"}, head_h, 0);
    check({p, "_coinh"}, coin_h, -200);
    check({p, "_coinv"}, coin_v, -40);
    check({p, "_coinvld"}, coin_valid, 0);
    check({p, "_tick"}, frame_tick, 0);
  endtask

  // One vsync pulse starting at a falling clock edge. Offsets have been
  // updated by the time the task returns.
  task automatic frame(input bit chk_timing, input bit do_restart);
    vs = 1'b1;
    @(negedge clk); if (chk_timing) check("tick_e1", frame_tick, 0);
    @(negedge clk); if (chk_timing) check("tick_e2", frame_tick, 0);
    @(negedge clk); if (chk_timing) check("tick_e3", frame_tick, 1);
    if (do_restart) restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    if (chk_timing) check("tick_e4", frame_tick, 0);
    vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press(input bit l, input bit r, input int n);
    btnl = l;
    btnr = r;
    repeat (n) @(negedge clk);
    btnl = 1'b0;
    btnr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // countdown: 3 ticks
    frame(1'b1, 1'b0); check("cd1_state", state, 0);
    frame(1'b1, 1'b0); check("cd2_state", state, 0);
    frame(1'b1, 1'b0); check("cd3_state", state, 1);
    check("cd3_logo", logo_h, 0);

    // logo scroll: 20 ticks
    for (int i = 1; i <= 20; i++) begin
      frame(1'b0, 1'b0);
      check($sformatf("logo%0d", i), logo_h, -30 * i);
      check($sformatf("logo%0d_state", i), state, (i == 20) ? 2 : 1);
    end

    // head slide: 10 ticks
    for (int i = 1; i <= 10; i++) begin
      frame(1'b0, 1'b0);
      check($sformatf("head%0d", i), head_v, -170 + 17 * i);
      check($sformatf("head%0d_state", i), state, (i == 10) ? 3 : 2);
    end
    check("run_coinvld", coin_valid, 1);
    check("run_coinh0", coin_h, -200);
    check("run_coinv0", coin_v, -40);

    // coin motion: 61 ticks, wraps after 59
    for (int i = 1; i <= 61; i++) begin
      frame(1'b0, 1'b0);
      check($sformatf("coinh%0d", i), coin_h, -200 + (i % 60));
      check($sformatf("coinv%0d", i), coin_v, -40 - 6 * (i % 60));
    end
    check("run_coinvld2", coin_valid, 1);
    check("run_state", state, 3);

    // buttons in RUN
    for (int k = 0; k < 3; k++) begin
      btnl = 1'b1; repeat (3) @(negedge clk);
      btnl = 1'b0; repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("bounce", head_h, 0);
    press(1'b1, 1'b0, 10); check("btnl1", head_h, 100);
    press(1'b1, 1'b0, 10); check("btnl_sat", head_h, 100);
    press(1'b1, 1'b1, 10); check("both", head_h, 100);
    press(1'b0, 1'b1, 10); check("btnr1", head_h, 0);
    press(1'b0, 1'b1, 10); check("btnr2", head_h, -100);
    press(1'b0, 1'b1, 10); check("btnr_sat", head_h, -100);
    press(1'b1, 1'b0, 30); check("hold", head_h, 0);
    press(1'b1, 1'b0, 10); check("btnl2", head_h, 100);

    // asynchronous reset mid-RUN, between clock edges
    #1 rst_n = 1'b0;
    #1 check_reset_vals("async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // press during COUNTDOWN is ignored
    press(1'b1, 1'b0, 10); check("press_cd", head_h, 0);

    // recovery, identical to first pass
    frame(1'b1, 1'b0); check("rc1_state", state, 0);
    frame(1'b0, 1'b0); check("rc2_state", state, 0);
    frame(1'b0, 1'b0); check("rc3_state", state, 1);
    frame(1'b0, 1'b0); check("rl1", logo_h, -30);
    frame(1'b0, 1'b0); check("rl2", logo_h, -60);

    // restart coincident with frame_tick
    frame(1'b1, 1'b1);
    check("rs_state", state, 0);
    check("rs_logo", logo_h, 0);
    check("rs_headv", head_v, -170);
    check("rs_coinvld", coin_valid, 0);
    frame(1'b0, 1'b0); check("rs1_state", state, 0);
    frame(1'b0, 1'b0); check("rs2_state", state, 0);
    frame(1'b0, 1'b0); check("rs3_state", state, 1);
    check("rs3_logo", logo_h, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
